// File: rtl/mux_scan_ctrl_if.sv
// Handshake and data bundle between the scan sequencer and whoever drives it.
// The master side drives the controls and returns the mux output; the sequencer is the slave.
interface mux_scan_ctrl_if #(
    parameter int SEL_W = 3,
    parameter int N_CH  = 8
);
    logic             start;
    logic             cont;
    logic             abort;
    logic             y_in;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             done;
    logic [N_CH-1:0]  data_out;

    modport master (
        output start, cont, abort, y_in,
        input  sel, busy, done, data_out
    );

    modport slave (
        input  start, cont, abort, y_in,
        output sel, busy, done, data_out
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 channel mux: walks sel over every channel, samples y once
// per channel after SETTLE extra cycles, and publishes the assembled word with a done pulse.
module mux_scan_ctrl #(
    parameter int SEL_W  = 3,
    parameter int N_CH   = 8,
    parameter int SETTLE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_scan_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(N_CH - 1);
    localparam logic [3:0]       SETTLE_CNT = 4'(SETTLE);

    state_t           state_reg;
    logic [3:0]       cnt_reg;
    logic [SEL_W-1:0] sel_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [N_CH-1:0]  shadow_reg;
    logic [N_CH-1:0]  data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            sel_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            shadow_reg <= '0;
            data_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg  <= WAIT;
                        sel_reg    <= '0;
                        cnt_reg    <= SETTLE_CNT;
                        busy_reg   <= 1'b1;
                        shadow_reg <= '0;
                    end
                end
                WAIT: begin
                    // Abort has priority over everything, including the final sample edge.
                    if (bus.abort) begin
                        state_reg  <= IDLE;
                        busy_reg   <= 1'b0;
                        sel_reg    <= '0;
                        cnt_reg    <= 4'd0;
                        shadow_reg <= '0;
                    end else if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else if (sel_reg != LAST_CH) begin
                        shadow_reg[sel_reg] <= bus.y_in;
                        sel_reg             <= sel_reg + SEL_W'(1);
                        cnt_reg             <= SETTLE_CNT;
                    end else begin
                        data_reg   <= {bus.y_in, shadow_reg[N_CH-2:0]};
                        done_reg   <= 1'b1;
                        sel_reg    <= '0;
                        shadow_reg <= '0;
                        if (bus.cont) begin
                            cnt_reg <= SETTLE_CNT;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            cnt_reg   <= 4'd0;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.sel      = sel_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.data_out = data_reg;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: two sequencers (SETTLE=0 and SETTLE=2), each driving
// a behavioural 8:1 mux, checked cycle by cycle against hand-computed expectations.
module tb_mux_scan_ctrl;
    logic       clk;
    logic       rst_n;
    logic [7:0] d0;
    logic [7:0] d2;
    int         n_vec;
    int         n_err;

    mux_scan_ctrl_if #(.SEL_W(3), .N_CH(8)) bus0 ();
    mux_scan_ctrl_if #(.SEL_W(3), .N_CH(8)) bus2 ();

    // The channel mux: y = d[sel]
    assign bus0.y_in = d0[bus0.sel];
    assign bus2.y_in = d2[bus2.sel];

    mux_scan_ctrl #(.SEL_W(3), .N_CH(8), .SETTLE(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    mux_scan_ctrl #(.SEL_W(3), .N_CH(8), .SETTLE(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic [2:0] s, input logic b,
                        input logic dn, input logic [7:0] dat);
        chk({tag, ".sel"},  32'(bus0.sel),      32'(s));
        chk({tag, ".busy"}, 32'(bus0.busy),     32'(b));
        chk({tag, ".done"}, 32'(bus0.done),     32'(dn));
        chk({tag, ".data"}, 32'(bus0.data_out), 32'(dat));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        d0 = 8'h00;
        d2 = 8'h00;
        bus0.start = 1'b0; bus0.cont = 1'b0; bus0.abort = 1'b0;
        bus2.start = 1'b0; bus2.cont = 1'b0; bus2.abort = 1'b0;
        rst_n = 1'b0;
        #1;
        chk0("rst", 3'd0, 1'b0, 1'b0, 8'h00);
        chk("rst2.busy", 32'(bus2.busy), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        $display("reset: checked");

        // 1: one-shot scan, SETTLE=0
        d0 = 8'hA5;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        chk0("t1.k", 3'd0, 1'b1, 1'b0, 8'h00);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk0($sformatf("t1.k+%0d", i), 3'(i), 1'b1, 1'b0, 8'h00);
        end
        tick();
        chk0("t1.done", 3'd0, 1'b0, 1'b1, 8'hA5);
        tick();
        chk0("t1.after", 3'd0, 1'b0, 1'b0, 8'hA5);
        $display("scan SETTLE=0 d=a5: data_out=%0h", bus0.data_out);

        // 2: one-shot scan, SETTLE=2
        d2 = 8'h3C;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        for (int j = 1; j < 24; j++) begin
            tick();
            chk($sformatf("t2.sel%0d", j), 32'(bus2.sel), 32'(j / 3));
            chk($sformatf("t2.done%0d", j), 32'(bus2.done), 32'd0);
        end
        tick();
        chk("t2.done", 32'(bus2.done), 32'd1);
        chk("t2.data", 32'(bus2.data_out), 32'h3C);
        chk("t2.busy", 32'(bus2.busy), 32'd0);
        tick();
        chk("t2.pulse", 32'(bus2.done), 32'd0);
        $display("scan SETTLE=2 d=3c: data_out=%0h", bus2.data_out);

        // 4: abort while sel==4, data_out keeps the earlier word
        d0 = 8'hC3;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        repeat (4) tick();
        chk("t4.sel4", 32'(bus0.sel), 32'd4);
        bus0.abort = 1'b1;
        tick();
        bus0.abort = 1'b0;
        chk0("t4.abort", 3'd0, 1'b0, 1'b0, 8'hA5);
        repeat (10) tick();
        chk0("t4.idle", 3'd0, 1'b0, 1'b0, 8'hA5);
        bus0.abort = 1'b1;
        tick();
        chk0("t4.abort_idle", 3'd0, 1'b0, 1'b0, 8'hA5);
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        chk("t4.start_wins", 32'(bus0.busy), 32'd1);
        tick();
        bus0.abort = 1'b0;
        chk0("t4.abort2", 3'd0, 1'b0, 1'b0, 8'hA5);
        $display("abort at sel=4: data_out=%0h", bus0.data_out);

        // 3: continuous mode, two back-to-back scans
        d0 = 8'hFF;
        bus0.cont = 1'b1;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk0($sformatf("t3a.k+%0d", i), 3'(i), 1'b1, 1'b0, 8'hA5);
        end
        tick();
        chk0("t3.done1", 3'd0, 1'b1, 1'b1, 8'hFF);
        d0 = 8'h00;
        bus0.cont = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk0($sformatf("t3b.k+%0d", i + 8), 3'(i), 1'b1, 1'b0, 8'hFF);
        end
        tick();
        chk0("t3.done2", 3'd0, 1'b0, 1'b1, 8'h00);
        tick();
        chk0("t3.after", 3'd0, 1'b0, 1'b0, 8'h00);
        $display("continuous scans: ff then %0h", bus0.data_out);

        // 6: abort on the final sample edge in continuous mode
        d0 = 8'h5A;
        bus0.cont = 1'b1;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        repeat (7) tick();
        chk("t6.sel7", 32'(bus0.sel), 32'd7);
        bus0.abort = 1'b1;
        tick();
        bus0.abort = 1'b0;
        bus0.cont = 1'b0;
        chk0("t6.abort", 3'd0, 1'b0, 1'b0, 8'h00);
        repeat (3) tick();
        chk0("t6.idle", 3'd0, 1'b0, 1'b0, 8'h00);
        $display("abort on final edge: data_out=%0h", bus0.data_out);

        // 5: restart ignored while busy, then async reset mid-scan
        d0 = 8'h96;
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        repeat (9) tick();
        chk0("t5.prime", 3'd0, 1'b0, 1'b0, 8'h96);
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        repeat (3) tick();
        chk("t5.sel3", 32'(bus0.sel), 32'd3);
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        chk0("t5.ignored", 3'd4, 1'b1, 1'b0, 8'h96);
        repeat (2) tick();
        chk("t5.sel6", 32'(bus0.sel), 32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk0("t5.rst", 3'd0, 1'b0, 1'b0, 8'h00);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk0("t5.post", 3'd0, 1'b0, 1'b0, 8'h00);
        $display("reset mid-scan: sel=%0d busy=%0d", bus0.sel, bus0.busy);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
